// File: rtl/imc_result_fifo.sv
// Result FIFO between the IMC read-op mux and the host: datapath words are queued
// and popped over an Avalon-MM slave (read latency 1) with sticky loss flags.
module imc_result_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  sys_clk_in,
    input  logic                  sys_reset_in,
    input  logic [DATA_WIDTH-1:0] result_data_in,
    input  logic                  result_valid_in,
    output logic                  result_ready_out,
    input  logic [1:0]            avalon_mm_address_in,
    input  logic                  avalon_mm_read_in,
    input  logic                  avalon_mm_write_in,
    input  logic [31:0]           avalon_mm_writedata_in,
    output logic                  avalon_mm_waitrequest_out,
    output logic [31:0]           avalon_mm_readdata_out,
    output logic                  avalon_mm_readdatavalid_out,
    output logic [DEPTH_LOG2:0]   fifo_count_out
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_INIT0,
        ST_INIT1,
        ST_RUN
    } init_state_e;

    init_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ready_q, ready_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic        waitreq;
    logic        rd_acc, wr_ctrl, flush;
    logic        push, pop, ovf_ev, udf_ev;
    logic        full, empty;
    logic [31:0] status;
    logic [31:0] head_word;

    logic unused_wdata;
    assign unused_wdata = ^avalon_mm_writedata_in[31:3];

    // Waitrequest held through the first edge after reset release.
    always_ff @(posedge sys_clk_in or negedge sys_reset_in) begin
        if (!sys_reset_in) begin
            state_q <= ST_INIT0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT0: state_d = ST_INIT1;
            ST_INIT1: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign waitreq = (state_q != ST_RUN);
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);

    always_comb begin
        status             = '0;
        status[31]         = ovf_q;
        status[30]         = udf_q;
        status[29]         = full;
        status[28]         = empty;
        status[CW-1:0]     = count_q;
        head_word          = '0;
        head_word[DATA_WIDTH-1:0] = mem_q[rd_ptr_q];
    end

    always_comb begin
        rd_acc  = avalon_mm_read_in & ~waitreq;
        // A simultaneous read strobe wins over the write.
        wr_ctrl = avalon_mm_write_in & ~avalon_mm_read_in & ~waitreq
                  & (avalon_mm_address_in == 2'd2);
        flush   = wr_ctrl & avalon_mm_writedata_in[0];

        push    = result_valid_in & ready_q & ~flush;
        ovf_ev  = result_valid_in & ~ready_q & ~flush;
        pop     = rd_acc & (avalon_mm_address_in == 2'd0) & ~empty;
        udf_ev  = rd_acc & (avalon_mm_address_in == 2'd0) & empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        ready_d = (count_d != CW'(DEPTH));

        ovf_d = ovf_ev | (ovf_q & ~(wr_ctrl & avalon_mm_writedata_in[1]));
        udf_d = udf_ev | (udf_q & ~(wr_ctrl & avalon_mm_writedata_in[2]));

        rvalid_d = rd_acc;
        rdata_d  = rdata_q;
        if (rd_acc) begin
            case (avalon_mm_address_in)
                2'd0:    rdata_d = empty ? '0 : head_word;
                2'd1:    rdata_d = status;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk_in or negedge sys_reset_in) begin
        if (!sys_reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_ff @(posedge sys_clk_in) begin
        if (push) mem_q[wr_ptr_q] <= result_data_in;
    end

    assign result_ready_out            = ready_q;
    assign avalon_mm_waitrequest_out   = waitreq;
    assign avalon_mm_readdata_out      = rdata_q;
    assign avalon_mm_readdatavalid_out = rvalid_q;
    assign fifo_count_out              = count_q;

endmodule

// File: tb/tb_imc_result_fifo.sv
// Scoreboard bench for imc_result_fifo: a queue-based reference model predicts each
// read response; a negedge monitor compares every readdatavalid pulse against it.
module tb_imc_result_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rdata_in;
    logic        rvalid_in;
    logic        ready;
    logic [1:0]  addr;
    logic        rd, wr;
    logic [31:0] wdata;
    logic        waitreq;
    logic [31:0] readdata;
    logic        rdv;
    logic [DL2:0] count;

    imc_result_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
        .sys_clk_in                  (clk),
        .sys_reset_in                (rst_n),
        .result_data_in              (rdata_in),
        .result_valid_in             (rvalid_in),
        .result_ready_out            (ready),
        .avalon_mm_address_in        (addr),
        .avalon_mm_read_in           (rd),
        .avalon_mm_write_in          (wr),
        .avalon_mm_writedata_in      (wdata),
        .avalon_mm_waitrequest_out   (waitreq),
        .avalon_mm_readdata_out      (readdata),
        .avalon_mm_readdatavalid_out (rdv),
        .fifo_count_out              (count)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] fifo_m[$];
    logic [31:0] exp_q[$];
    bit          ovf_m, udf_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_m();
        int unsigned sz = fifo_m.size();
        return (ovf_m ? 32'h8000_0000 : 0) + (udf_m ? 32'h4000_0000 : 0)
             + (sz == DEPTH ? 32'h2000_0000 : 0) + (sz == 0 ? 32'h1000_0000 : 0) + sz;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rdv) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_readdatavalid", 32'd1, 32'd0);
            end else begin
                chk("readdata", readdata, exp_q.pop_front());
            end
        end
    end

    // One clock cycle of stimulus, issued at a negedge; model uses pre-edge state.
    task automatic step(input bit v, input logic [31:0] d, input bit r, input bit w,
                        input logic [1:0] a, input logic [31:0] wd);
        bit          wr_c, fl, rdy, pop;
        int unsigned sz;
        rvalid_in = v; rdata_in = d; rd = r; wr = w; addr = a; wdata = wd;
        sz   = fifo_m.size();
        rdy  = (sz < DEPTH);
        wr_c = w && !r && (a == 2'd2);
        fl   = wr_c && wd[0];
        if (r) begin
            if (a == 2'd0)      exp_q.push_back(sz > 0 ? fifo_m[0] : 32'd0);
            else if (a == 2'd1) exp_q.push_back(status_m());
            else                exp_q.push_back(32'd0);
        end
        pop   = r && (a == 2'd0) && (sz > 0);
        udf_m = (r && (a == 2'd0) && (sz == 0)) || (udf_m && !(wr_c && wd[2]));
        ovf_m = (v && !rdy && !fl) || (ovf_m && !(wr_c && wd[1]));
        if (fl) begin
            fifo_m.delete();
        end else begin
            if (pop) void'(fifo_m.pop_front());
            if (v && rdy) fifo_m.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        chk("count", 32'(count), fifo_m.size());
        chk("ready", 32'(ready), (fifo_m.size() < DEPTH) ? 32'd1 : 32'd0);
        chk("waitrequest", 32'(waitreq), 32'd0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic push_word(input logic [31:0] d);
        step(1'b1, d, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic rd_addr(input logic [1:0] a);
        step(1'b0, '0, 1'b1, 1'b0, a, '0);
    endtask

    task automatic ctrl(input logic [31:0] wd);
        step(1'b0, '0, 1'b0, 1'b1, 2'd2, wd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; rvalid_in = 0; rdata_in = '0; rd = 0; wr = 0; addr = '0; wdata = '0;
        ovf_m = 0; udf_m = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_waitrequest", 32'(waitreq), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rdv", 32'(rdv), 32'd0);
        chk("rst_readdata", readdata, 32'd0);

        // Read held during the waitrequest window must not be accepted.
        rst_n = 1'b1; rd = 1'b1; addr = 2'd1;
        @(posedge clk); @(negedge clk);
        chk("wait_after_edge1", 32'(waitreq), 32'd1);
        @(posedge clk); @(negedge clk);
        rd = 1'b0;
        chk("wait_after_edge2", 32'(waitreq), 32'd0);
        chk("status_after_reset_model", status_m(), 32'h1000_0000);
        rd_addr(2'd1);
        idle();

        for (int i = 1; i <= 3; i++) push_word(32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 3; i++) rd_addr(2'd0);
        idle();

        for (int i = 0; i < 17; i++) push_word(32'h1111_0000 + 32'(i));
        chk("ready_after_17", 32'(ready), 32'd0);
        rd_addr(2'd1);
        ctrl(32'h2);
        rd_addr(2'd1);
        for (int i = 0; i < 16; i++) rd_addr(2'd0);
        idle();

        rd_addr(2'd0);
        rd_addr(2'd1);
        ctrl(32'h4);
        rd_addr(2'd1);
        rd_addr(2'd2);
        rd_addr(2'd3);
        idle();

        for (int i = 0; i < 5; i++) push_word($urandom);
        for (int i = 0; i < 40; i++) step(1'b1, $urandom, 1'b1, 1'b0, 2'd0, '0);
        rd_addr(2'd1);

        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 32'h1);
        rd_addr(2'd1);

        // Overflow event and its clear in the same cycle: the event wins.
        for (int i = 0; i < 16; i++) push_word($urandom);
        step(1'b1, 32'h5555_5555, 1'b0, 1'b1, 2'd2, 32'h2);
        rd_addr(2'd1);
        step(1'b0, '0, 1'b1, 1'b1, 2'd2, 32'h1);
        ctrl(32'h1);

        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 32'($urandom_range(0, 7)));
        end
        idle(); idle();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        ctrl(32'h1);
        for (int i = 0; i < 4; i++) push_word(32'hC0DE_0000 + 32'(i));
        rd = 1'b1; addr = 2'd0;
        @(posedge clk);
        #2;
        chk("midburst_rdv", 32'(rdv), 32'd1);
        chk("midburst_data", readdata, 32'hC0DE_0000);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdv", 32'(rdv), 32'd0);
        chk("async_rst_readdata", readdata, 32'd0);
        chk("async_rst_waitrequest", 32'(waitreq), 32'd1);
        chk("async_rst_ready", 32'(ready), 32'd1);
        chk("async_rst_count", 32'(count), 32'd0);
        rd = 1'b0;
        fifo_m.delete(); exp_q.delete(); ovf_m = 0; udf_m = 0;
        @(negedge clk); @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
